keypad_scan_ctrl: RTL and testbench

Scan sequencer and key-event queue for the 4-row × 3-column keypad. Drives the one-hot row strobes, samples the 3-bit column return once per row, and debounces whole-keypad frames. On each clean single-key press it queues a 4-bit key code in a small FIFO, which downstream logic (the 7-segment display driver, the command decoder) drains through a valid/ready handshake.

---
 rtl/keypad_scan_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: row strobing, frame debounce, press detection and key-event queue.
module keypad_scan_ctrl #(
    parameter int unsigned TICK_DIV       = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t            state, state_next;
    logic [3:0]        row_next;
    logic [2:0]        col_s1, col_s2;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;

    logic [8:0]        frame_build;
    logic [11:0]       raw_frame;
    logic              frame_done;

    logic [11:0]       cand, cand_next, accepted, prev_acc;
    logic [DB_W-1:0]   db_cnt, db_cnt_next;
    logic              accept_c, accept_q;

    logic [3:0]        press_code, push_code;
    logic              press_c, push_q;

    logic [3:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0]  fifo_cnt, cnt_after_pop, fifo_cnt_next;
    logic              pop_c, full_c, wr_en_c, drop_c;
    logic [3:0]        head_next;

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    // Two-flop synchroniser for the column return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 3'b000;
            col_s2 <= 3'b000;
        end else begin
            col_s1 <= column;
            col_s2 <= col_s1;
        end
    end

    // Row-step prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end

    // Scan state and registered row strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
            row   <= 4'b0001;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    // Scan sequencing: advance one row per tick.
    always_comb begin
        state_next = state;
        row_next   = row;
        if (tick) begin
            case (state)
                S0: begin state_next = S1; row_next = 4'b0010; end
                S1: begin state_next = S2; row_next = 4'b0100; end
                S2: begin state_next = S3; row_next = 4'b1000; end
                S3: begin state_next = S0; row_next = 4'b0001; end
            endcase
        end
    end

    // Column capture into the frame under construction; S3 tick completes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_build <= '0;
            raw_frame   <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= tick && (state == S3);
            if (tick) begin
                case (state)
                    S0: frame_build[2:0] <= col_s2;
                    S1: frame_build[5:3] <= col_s2;
                    S2: frame_build[8:6] <= col_s2;
                    S3: raw_frame        <= {col_s2, frame_build};
                endcase
            end
        end
    end

    // Frame debounce: count identical frames, accept on reaching the threshold.
    always_comb begin
        cand_next   = cand;
        db_cnt_next = db_cnt;
        accept_c    = 1'b0;
        if (frame_done) begin
            if (raw_frame == cand) begin
                if (db_cnt < DB_W'(DEBOUNCE_SCANS)) begin
                    db_cnt_next = db_cnt + DB_W'(1);
                    accept_c    = (db_cnt == DB_W'(DEBOUNCE_SCANS - 1));
                end
            end else begin
                cand_next   = raw_frame;
                db_cnt_next = DB_W'(1);
                accept_c    = (DEBOUNCE_SCANS == 1);
            end
        end
    end

    // Debounce state and accepted frame history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            db_cnt   <= '0;
            accept_q <= 1'b0;
            accepted <= '0;
            prev_acc <= '0;
            key_held <= 1'b0;
        end else begin
            cand     <= cand_next;
            db_cnt   <= db_cnt_next;
            accept_q <= accept_c;
            if (accept_c) begin
                prev_acc <= accepted;
                accepted <= cand_next;
                key_held <= |cand_next;
            end
        end
    end

    // Press detection: single key from an all-released frame.
    always_comb begin
        press_code = 4'h0;
        for (int i = 0; i < 12; i++) begin
            if (accepted[i]) press_code = 4'(i);
        end
        press_c = accept_q && (accepted != 12'h000)
                  && ((accepted & (accepted - 12'd1)) == 12'h000)
                  && (prev_acc == 12'h000);
    end

    // Registered press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q    <= 1'b0;
            push_code <= 4'h0;
        end else begin
            push_q    <= press_c;
            push_code <= press_code;
        end
    end

    // Queue control: push/pop arbitration and look-ahead head selection.
    always_comb begin
        pop_c         = key_valid && key_ready;
        full_c        = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        wr_en_c       = push_q && (!full_c || pop_c);
        drop_c        = push_q && full_c && !pop_c;
        cnt_after_pop = fifo_cnt - CNT_W'(pop_c);
        fifo_cnt_next = cnt_after_pop + CNT_W'(wr_en_c);
        rd_next       = rd_ptr + PTR_W'(pop_c);
        if (cnt_after_pop == '0) head_next = wr_en_c ? push_code : 4'h0;
        else                     head_next = mem[rd_next];
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= push_code;
    end

    // Queue pointers and registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overflow  <= 1'b0;
        end else begin
            fifo_cnt  <= fifo_cnt_next;
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_ptr + PTR_W'(wr_en_c);
            key_valid <= (fifo_cnt_next != '0);
            key_code  <= head_next;
            overflow  <= drop_c;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a 4x3 keypad model.
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  column;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overflow;

    logic [11:0] keys;
    int          n_cmp;
    int          n_err;

    keypad_scan_ctrl #(
        .TICK_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .column    (column),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    // Keypad model: strobed row returns its closed keys on the columns.
    assign column = (row[0] ? keys[2:0]  : 3'b000) |
                    (row[1] ? keys[5:3]  : 3'b000) |
                    (row[2] ? keys[8:6]  : 3'b000) |
                    (row[3] ? keys[11:9] : 3'b000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cycles(input int n, output int rises, output int ovf);
        logic prev;
        prev  = key_valid;
        rises = 0;
        ovf   = 0;
        repeat (n) begin
            @(negedge clk);
            if (key_valid && !prev) rises++;
            if (overflow) ovf++;
            prev = key_valid;
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit got, output int since);
        logic [3:0] last;
        last  = row;
        since = 99;
        got   = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (last == 4'b1000 && row == 4'b0001) since = 0;
            else since++;
            last = row;
            if (key_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wrap(input string tag);
        logic [3:0] last;
        bit         seen;
        last = row;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (last == 4'b1000 && row == 4'b0001) begin
                seen = 1'b1;
                break;
            end
            last = row;
        end
        if (!seen) check(tag, 32'(seen), 32'd1);
    endtask

    task automatic press_release(input int code, output int rises, output int ovf);
        int r, o;
        keys       = '0;
        keys[code] = 1'b1;
        run_cycles(64, r, o);
        rises = r;
        ovf   = o;
        keys  = '0;
        run_cycles(64, r, o);
        rises += r;
        ovf   += o;
    endtask

    initial begin
        bit got;
        int since, r, o, tr, to;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        key_ready = 1'b1;
        keys      = 12'h080;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row), 32'h1);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        // Row sequence, 4 clk per row.
        repeat (3) @(negedge clk);
        check("row_s0", 32'(row), 32'h1);
        @(negedge clk);
        check("row_s1", 32'(row), 32'h2);
        repeat (4) @(negedge clk);
        check("row_s2", 32'(row), 32'h4);
        repeat (4) @(negedge clk);
        check("row_s3", 32'(row), 32'h8);
        repeat (4) @(negedge clk);
        check("row_wrap", 32'(row), 32'h1);

        // Single key (2,1) held: one event, code 7, valid for one clk.
        wait_valid(100, got, since);
        check("k7_valid", 32'(got), 32'd1);
        check("k7_code", 32'(key_code), 32'd7);
        check("k7_latency", 32'(since), 32'd3);
        check("k7_held", 32'(key_held), 32'd1);
        @(negedge clk);
        check("k7_one_clk", 32'(key_valid), 32'd0);
        check("k7_empty_code", 32'(key_code), 32'd0);
        run_cycles(64, r, o);
        check("k7_hold_noevt", 32'(r), 32'd0);
        keys = 12'h000;
        run_cycles(64, r, o);
        check("k7_rel_noevt", 32'(r), 32'd0);
        check("k7_rel_held", 32'(key_held), 32'd0);

        // Bounce on (0,0), toggling once per frame, then held.
        wait_wrap("bounce_align");
        tr = 0;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 12'h001 : 12'h000;
            run_cycles(16, r, o);
            tr += r;
        end
        check("bounce_noevt", 32'(tr), 32'd0);
        keys = 12'h001;
        wait_valid(80, got, since);
        check("k0_valid", 32'(got), 32'd1);
        check("k0_code", 32'(key_code), 32'd0);
        check("k0_latency", 32'(since), 32'd3);
        run_cycles(48, r, o);
        check("k0_single", 32'(r), 32'd0);
        keys = 12'h000;
        run_cycles(64, r, o);
        check("k0_rel_held", 32'(key_held), 32'd0);

        // Two keys (1,0)+(3,2), partial release, full release, then (3,2).
        keys = 12'h808;
        run_cycles(64, r, o);
        check("multi_noevt", 32'(r), 32'd0);
        check("multi_held", 32'(key_held), 32'd1);
        keys = 12'h008;
        run_cycles(64, r, o);
        check("partial_noevt", 32'(r), 32'd0);
        check("partial_held", 32'(key_held), 32'd1);
        keys = 12'h000;
        run_cycles(64, r, o);
        check("allrel_noevt", 32'(r), 32'd0);
        check("allrel_held", 32'(key_held), 32'd0);
        keys = 12'h800;
        wait_valid(80, got, since);
        check("k11_valid", 32'(got), 32'd1);
        check("k11_code", 32'(key_code), 32'd11);
        keys = 12'h000;
        run_cycles(64, r, o);

        // Consumer stalled: codes 1..5, fifth overflows.
        key_ready = 1'b0;
        tr = 0;
        to = 0;
        for (int c = 1; c <= 5; c++) begin
            press_release(c, r, o);
            tr += r;
            to += o;
        end
        check("stall_ovf_pulses", 32'(to), 32'd1);
        check("stall_valid_rises", 32'(tr), 32'd1);
        key_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", 32'(key_valid), 32'd1);
            check("drain_code", 32'(key_code), 32'(k));
            @(negedge clk);
        end
        check("drain_empty", 32'(key_valid), 32'd0);
        check("drain_code0", 32'(key_code), 32'd0);

        // Full queue with a pop in the same cycle as a push.
        key_ready = 1'b0;
        to = 0;
        for (int c = 6; c <= 9; c++) begin
            press_release(c, r, o);
            to += o;
        end
        check("fill_no_ovf", 32'(to), 32'd0);
        wait_wrap("full_align0");
        keys = 12'h400;
        wait_wrap("full_align1");
        wait_wrap("full_align2");
        repeat (2) @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_valid", 32'(key_valid), 32'd1);
        check("full_pp_code", 32'(key_code), 32'd7);
        keys = 12'h000;
        run_cycles(64, r, o);
        check("full_pp_no_ovf_after", 32'(o), 32'd0);
        key_ready = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            check("full_drain_code", 32'(key_code), 32'(k));
            @(negedge clk);
        end
        check("full_drain_empty", 32'(key_valid), 32'd0);

        // Mid-frame reset with two codes queued.
        key_ready = 1'b0;
        press_release(1, r, o);
        press_release(2, r, o);
        check("prerst_valid", 32'(key_valid), 32'd1);
        check("prerst_code", 32'(key_code), 32'd1);
        wait_wrap("rst_align");
        repeat (6) @(negedge clk);
        check("prerst_row", 32'(row), 32'h2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_row", 32'(row), 32'h1);
        check("midrst_code", 32'(key_code), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_row_s0", 32'(row), 32'h1);
        @(negedge clk);
        check("postrst_row_s1", 32'(row), 32'h2);
        run_cycles(64, r, o);
        check("postrst_noevt", 32'(r), 32'd0);
        check("postrst_no_ovf", 32'(o), 32'd0);
        check("postrst_valid", 32'(key_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
